ram_be_fwd: RTL and testbench
=============================

Name: ram_be_fwd

Overview:
Parametrised simple-dual-port on-chip RAM, successor to the team's registered-input 1R1W RAM primitive. It adds per-byte write strobes and same-cycle write-to-read forwarding, so reads are always coherent. It also adds an optional output pipeline register and a hardware clear sequencer with a busy flag. It sits under the DNN buffers (weight/activation scratchpads) that need zero-initialised memory after reset and partial-word updates.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH
BYTE_WIDTH, 8, bits per write-strobe lane; NUM_BYTES = DATA_WIDTH/BYTE_WIDTH
ADDR_WIDTH, 10, address bits; depth DEPTH = 2^ADDR_WIDTH words exactly
RAM_TYPE, "block", RAM_STYLE synthesis attribute on the memory array
OUT_REG, 0, 1 adds one output register stage on s_read_data/s_read_valid
CLEAR_ON_RESET, 1, 1 runs the clear sequence automatically after reset

Ports:
clk  input  1  clock; all logic on rising edge
resetn  input  1  synchronous, active-low reset
s_read_req  input  1  read request, sampled every cycle
s_read_addr  input  ADDR_WIDTH  read address
s_read_data  output  DATA_WIDTH  read data
s_read_valid  output  1  one-cycle pulse per accepted read
s_write_req  input  1  write request
s_write_addr  input  ADDR_WIDTH  write address
s_write_data  input  DATA_WIDTH  write data
s_write_strb  input  NUM_BYTES  byte enables; bit i enables bits [i*BYTE_WIDTH +: BYTE_WIDTH]
clear_req  input  1  start clear sequence (pulse)
busy  output  1  high while clearing; requests are ignored

Behaviour:
- Reset (resetn=0 at an edge): s_read_data=0, s_read_valid=0, all stage valids=0, clear counter=0, FSM=CLEAR if CLEAR_ON_RESET else IDLE, busy=CLEAR_ON_RESET. Memory contents are not reset.
- Write path: request in cycle T is registered at the end of T (addr/data/strb/valid). Memory is updated at the end of T+1, enabled bytes only. strb=0 performs no memory change.
- Read path: request in cycle T is registered at the end of T and the array is read at the end of T+1.
  - s_read_data/s_read_valid appear in cycle T+2 (OUT_REG=0) or T+3 (OUT_REG=1).
  - s_read_valid is high exactly one cycle per accepted read; back-to-back reads give one result per cycle.
  - s_read_data holds its last value when no read is returning.
- Coherency: a read in cycle T returns memory state including all writes accepted in cycles <= T (write-before-read).
  - Writes from cycles < T are already committed.
  - A same-cycle write to the same address is forwarded byte-wise: strobed bytes come from the write data, others from the array.
- FSM states:
  - IDLE: clear_req=1 in cycle T moves to CLEAR for cycle T+1. Read/write requests in cycle T are still accepted and complete normally.
  - CLEAR: each cycle, counter c (0..DEPTH-1) is injected into the write input stage as addr=c, data=0, strb=all ones. External s_write_req/s_read_req are ignored (no write, no s_read_valid). After c=DEPTH-1 the FSM goes to IDLE. Cycles spent in CLEAR = DEPTH.
- busy equals (FSM==CLEAR).
  - After clear_req in cycle T: busy is high in cycles T+1..T+DEPTH and low in T+DEPTH+1.
  - After reset release (first cycle with resetn=1 is R): busy is high through R+DEPTH-1 and low at R+DEPTH.
- The first post-clear read (any address, including DEPTH-1) returns 0 via normal commit or forwarding.
- clear_req while busy is ignored; no restart.
- Reset mid-clear: sequence restarts from c=0 if CLEAR_ON_RESET, else FSM returns to IDLE (memory partially cleared, contents undefined). Any in-flight read/write is dropped.
- Address counter width is ADDR_WIDTH+1 internally; no wrap is visible externally.

Test Plan:
1. CLEAR_ON_RESET=1, release reset at R: busy=1 for exactly DEPTH=1024 cycles. Then read addr 0, 513 and 1023: each returns 0x00000000 with valid 2 cycles after request.
2. Write 0xDEADBEEF strb=4'hF to addr 5 in cycle T, read addr 5 in the same cycle T: data=0xDEADBEEF, valid in cycle T+2. Repeat with OUT_REG=1: data in T+3.
3. Word 0x11223344 at addr 7. Write 0xAABBCCDD strb=4'b0101 to addr 7, then read in the following cycle: 0x11BB33DD. Repeat with same-cycle read: same result (forwarding merge).
4. Reads to addr 0..15 on 16 consecutive cycles, with a write to addr 3 interleaved in the read's cycle: 16 contiguous valid pulses, in order, and addr 3 shows the new data.
5. clear_req during a stream of writes: write in the clear_req cycle commits before the clear zeroes it. Writes and reads while busy=1 have no effect and produce no valid. All words read 0 afterwards.
6. Assert resetn=0 at clear counter 300, hold 2 cycles, release: busy is high for exactly 1024 further cycles. clear_req issued while busy does not extend this.

Source files
------------

// File: rtl/ram_be_fwd_if.sv
// Request/response bus of ram_be_fwd: read port, byte-strobed write port.
interface ram_be_fwd_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 10
);
  localparam int unsigned NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;

  logic                  s_read_req;
  logic [ADDR_WIDTH-1:0] s_read_addr;
  logic [DATA_WIDTH-1:0] s_read_data;
  logic                  s_read_valid;
  logic                  s_write_req;
  logic [ADDR_WIDTH-1:0] s_write_addr;
  logic [DATA_WIDTH-1:0] s_write_data;
  logic [NUM_BYTES-1:0]  s_write_strb;

  modport master (
    output s_read_req, s_read_addr, s_write_req, s_write_addr, s_write_data, s_write_strb,
    input  s_read_data, s_read_valid
  );

  modport slave (
    input  s_read_req, s_read_addr, s_write_req, s_write_addr, s_write_data, s_write_strb,
    output s_read_data, s_read_valid
  );
endinterface

// File: rtl/ram_be_fwd.sv
// Simple-dual-port RAM with byte strobes, same-cycle write-to-read forwarding,
// optional output register and a clear sequencer that zero-fills the array.
module ram_be_fwd #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BYTE_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter string       RAM_TYPE       = "block",
  parameter int unsigned OUT_REG        = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic         clk,
  input  logic         resetn,
  ram_be_fwd_if.slave  bus,
  input  logic         clear_req,
  output logic         busy
);

  localparam int unsigned NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   clr_cnt_q, clr_cnt_d;

  logic                  wr_valid_q, wr_valid_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [NUM_BYTES-1:0]  wr_strb_q, wr_strb_d;

  logic                  rd_valid_q, rd_valid_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;

  logic                  ret_valid_q, ret_valid_d;
  logic [DATA_WIDTH-1:0] fwd_mask_q, fwd_mask_d;
  logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;
  logic [DATA_WIDTH-1:0] rd_mem_q;
  logic [DATA_WIDTH-1:0] ret_data;
  logic                  mem_we;

  assign busy = (state_q == ST_CLEAR);

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    wr_valid_d = bus.s_write_req;
    wr_addr_d  = bus.s_write_addr;
    wr_data_d  = bus.s_write_data;
    wr_strb_d  = bus.s_write_strb;
    rd_valid_d = bus.s_read_req;
    rd_addr_d  = bus.s_read_addr;
    unique case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
      ST_CLEAR: begin
        wr_valid_d = 1'b1;
        wr_addr_d  = clr_cnt_q[ADDR_WIDTH-1:0];
        wr_data_d  = '0;
        wr_strb_d  = '1;
        rd_valid_d = 1'b0;
        if (clr_cnt_q == CNT_LAST) begin
          state_d   = ST_IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A write staged alongside a read to the same word commits on the same edge the
  // array is read; capture its strobed bytes so they override the stale array data.
  always_comb begin
    ret_valid_d = rd_valid_q;
    fwd_mask_d  = fwd_mask_q;
    fwd_data_d  = fwd_data_q;
    if (rd_valid_q) begin
      fwd_data_d = wr_data_q;
      for (int unsigned i = 0; i < NUM_BYTES; i++) begin
        fwd_mask_d[i*BYTE_WIDTH +: BYTE_WIDTH] =
          {BYTE_WIDTH{wr_valid_q && (wr_addr_q == rd_addr_q) && wr_strb_q[i]}};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      clr_cnt_q   <= '0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_strb_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_addr_q   <= '0;
      ret_valid_q <= 1'b0;
      // Full mask over zero data makes the read result 0 without resetting the array read register.
      fwd_mask_q  <= '1;
      fwd_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_strb_q   <= wr_strb_d;
      rd_valid_q  <= rd_valid_d;
      rd_addr_q   <= rd_addr_d;
      ret_valid_q <= ret_valid_d;
      fwd_mask_q  <= fwd_mask_d;
      fwd_data_q  <= fwd_data_d;
    end
  end

  assign mem_we = resetn && wr_valid_q;

  if (RAM_TYPE == "distributed") begin : g_mem
    (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
      if (mem_we) begin
        for (int unsigned i = 0; i < NUM_BYTES; i++) begin
          if (wr_strb_q[i]) mem[wr_addr_q][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data_q[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
      if (rd_valid_q) rd_mem_q <= mem[rd_addr_q];
    end
  end else begin : g_mem
    (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
      if (mem_we) begin
        for (int unsigned i = 0; i < NUM_BYTES; i++) begin
          if (wr_strb_q[i]) mem[wr_addr_q][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data_q[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
      if (rd_valid_q) rd_mem_q <= mem[rd_addr_q];
    end
  end

  assign ret_data = (rd_mem_q & ~fwd_mask_q) | (fwd_data_q & fwd_mask_q);

  if (OUT_REG != 0) begin : g_out_reg
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

    always_comb begin
      out_valid_d = ret_valid_q;
      out_data_d  = out_data_q;
      if (ret_valid_q) out_data_d = ret_data;
    end

    always_ff @(posedge clk) begin
      if (!resetn) begin
        out_valid_q <= 1'b0;
        out_data_q  <= '0;
      end else begin
        out_valid_q <= out_valid_d;
        out_data_q  <= out_data_d;
      end
    end

    assign bus.s_read_valid = out_valid_q;
    assign bus.s_read_data  = out_data_q;
  end else begin : g_no_out_reg
    assign bus.s_read_valid = ret_valid_q;
    assign bus.s_read_data  = ret_data;
  end

endmodule

// File: tb/tb_ram_be_fwd.sv
// Randomised scoreboard bench for ram_be_fwd; runs OUT_REG=0 and OUT_REG=1 instances in lockstep.
module tb_ram_be_fwd;
  localparam int unsigned DW    = 32;
  localparam int unsigned BW    = 8;
  localparam int unsigned AW    = 10;
  localparam int unsigned NB    = DW / BW;
  localparam int unsigned DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic clear_req = 1'b0;
  logic busy0, busy1;

  ram_be_fwd_if #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .ADDR_WIDTH(AW)) bus0 ();
  ram_be_fwd_if #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .ADDR_WIDTH(AW)) bus1 ();

  ram_be_fwd #(
    .DATA_WIDTH(DW), .BYTE_WIDTH(BW), .ADDR_WIDTH(AW),
    .RAM_TYPE("block"), .OUT_REG(0), .CLEAR_ON_RESET(1)
  ) dut0 (
    .clk(clk), .resetn(resetn), .bus(bus0), .clear_req(clear_req), .busy(busy0)
  );

  ram_be_fwd #(
    .DATA_WIDTH(DW), .BYTE_WIDTH(BW), .ADDR_WIDTH(AW),
    .RAM_TYPE("block"), .OUT_REG(1), .CLEAR_ON_RESET(1)
  ) dut1 (
    .clk(clk), .resetn(resetn), .bus(bus1), .clear_req(clear_req), .busy(busy1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: a plain word array, a busy window in cycle numbers, and expected responses.
  logic [DW-1:0] model_mem [DEPTH];
  int            busy_first = 1;
  int            busy_last  = 0;
  logic [DW-1:0] exp_data [2][$];
  int            exp_cyc  [2][$];
  logic [DW-1:0] last_data [2];
  int            tests = 0;
  int            fails = 0;

  function automatic void cmp(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic bit model_busy(int c);
    return (c >= busy_first) && (c <= busy_last);
  endfunction

  function automatic void check(int k, logic v, logic [DW-1:0] d);
    if (v) begin
      if (exp_data[k].size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid%0d: got valid with data 0x%0h, expected no valid (cycle %0d)", k, d, cyc);
      end else begin
        cmp($sformatf("rdata%0d", k), d, exp_data[k].pop_front());
        cmp($sformatf("rlatency%0d", k), cyc, exp_cyc[k].pop_front());
      end
      last_data[k] = d;
    end else begin
      cmp($sformatf("hold%0d", k), d, last_data[k]);
    end
  endfunction

  task automatic drive(input bit rd, input int ra, input bit wr, input int wa,
                       input logic [DW-1:0] wd, input logic [NB-1:0] ws, input bit clr);
    bus0.s_read_req   = rd;      bus1.s_read_req   = rd;
    bus0.s_read_addr  = AW'(ra); bus1.s_read_addr  = AW'(ra);
    bus0.s_write_req  = wr;      bus1.s_write_req  = wr;
    bus0.s_write_addr = AW'(wa); bus1.s_write_addr = AW'(wa);
    bus0.s_write_data = wd;      bus1.s_write_data = wd;
    bus0.s_write_strb = ws;      bus1.s_write_strb = ws;
    clear_req = clr;
    if (resetn && !model_busy(cyc)) begin
      // write-before-read within a cycle
      if (wr) begin
        for (int b = 0; b < int'(NB); b++) begin
          if (ws[b]) model_mem[wa][b*BW +: BW] = wd[b*BW +: BW];
        end
      end
      if (rd) begin
        exp_data[0].push_back(model_mem[ra]); exp_cyc[0].push_back(cyc + 2);
        exp_data[1].push_back(model_mem[ra]); exp_cyc[1].push_back(cyc + 3);
      end
      if (clr) begin
        for (int a = 0; a < int'(DEPTH); a++) model_mem[a] = '0;
        busy_first = cyc + 1;
        busy_last  = cyc + int'(DEPTH);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 0, 1'b0, 0, '0, '0, 1'b0);
  endtask

  task automatic rand_cycle(input int amax, input bit allow_clr);
    bit            rb, wb, cb;
    logic [DW-1:0] wd;
    logic [NB-1:0] ws;
    rb = 1'($urandom);
    wb = 1'($urandom);
    cb = allow_clr && ($urandom_range(0, 15) == 0);
    wd = $urandom;
    ws = NB'($urandom);
    drive(rb, int'($urandom_range(0, amax)), wb, int'($urandom_range(0, amax)), wd, ws, cb);
  endtask

  task automatic do_reset(input int n);
    resetn = 1'b0;
    if (!model_busy(cyc)) busy_first = cyc + 1;
    busy_last = 32'h7fff_ffff;
    for (int k = 0; k < 2; k++) begin
      exp_data[k].delete();
      exp_cyc[k].delete();
    end
    repeat (n) idle();
    resetn = 1'b1;
    busy_last = cyc + int'(DEPTH) - 1;
    for (int a = 0; a < int'(DEPTH); a++) model_mem[a] = '0;
  endtask

  // Monitor: samples on the falling edge, compares busy and read responses.
  bit started = 1'b0;
  bit rst_now;
  initial begin
    forever begin
      @(posedge clk);
      rst_now = !resetn;
      @(negedge clk);
      if (rst_now) begin
        started      = 1'b1;
        last_data[0] = '0;
        last_data[1] = '0;
      end
      if (started) begin
        cmp("busy0", busy0, model_busy(cyc));
        cmp("busy1", busy1, model_busy(cyc));
        check(0, bus0.s_read_valid, bus0.s_read_data);
        check(1, bus1.s_read_valid, bus1.s_read_data);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time %0t exceeded limit 1000000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(3);
    while (model_busy(cyc)) rand_cycle(int'(DEPTH) - 1, 1'b0);

    // Post-clear reads, including the last address
    drive(1'b1, 0,    1'b0, 0, '0, '0, 1'b0);
    drive(1'b1, 513,  1'b0, 0, '0, '0, 1'b0);
    drive(1'b1, 1023, 1'b0, 0, '0, '0, 1'b0);

    // Same-cycle full-word write and read
    drive(1'b1, 5, 1'b1, 5, 32'hDEAD_BEEF, 4'hF, 1'b0);
    idle();

    // Partial strobe: following-cycle read, then same-cycle read
    drive(1'b0, 0, 1'b1, 7, 32'h1122_3344, 4'hF, 1'b0);
    drive(1'b0, 0, 1'b1, 7, 32'hAABB_CCDD, 4'b0101, 1'b0);
    drive(1'b1, 7, 1'b0, 0, '0, '0, 1'b0);
    drive(1'b0, 0, 1'b1, 7, 32'h1122_3344, 4'hF, 1'b0);
    drive(1'b1, 7, 1'b1, 7, 32'hAABB_CCDD, 4'b0101, 1'b0);
    idle();

    // Read stream 0..15 with a write to 3 in the cycle that reads 3
    for (int i = 0; i < 16; i++) drive(1'b1, i, (i == 3), 3, 32'h5A5A_0003, 4'hF, 1'b0);
    repeat (4) idle();

    // Random traffic over a small window to provoke collisions
    repeat (400) rand_cycle(31, 1'b0);
    repeat (4) idle();

    // Clear during a write stream; same-cycle write/read in the clear_req cycle
    repeat (5) rand_cycle(31, 1'b0);
    drive(1'b1, 9, 1'b1, 9, 32'h0BAD_F00D, 4'hF, 1'b1);
    while (model_busy(cyc)) rand_cycle(31, 1'b1);
    for (int a = 0; a < int'(DEPTH); a++) drive(1'b1, a, 1'b0, 0, '0, '0, 1'b0);
    repeat (4) idle();

    // Reset at clear counter 300; clear_req while busy must not extend the window
    repeat (20) rand_cycle(63, 1'b0);
    repeat (4) idle();
    drive(1'b0, 0, 1'b0, 0, '0, '0, 1'b1);
    while (cyc < busy_first + 300) idle();
    do_reset(2);
    repeat (10) drive(1'b0, 0, 1'b0, 0, '0, '0, 1'b1);
    while (model_busy(cyc)) rand_cycle(63, 1'b1);
    drive(1'b1, 0,    1'b0, 0, '0, '0, 1'b0);
    drive(1'b1, 300,  1'b0, 0, '0, '0, 1'b0);
    drive(1'b1, 1023, 1'b0, 0, '0, '0, 1'b0);
    repeat (50) rand_cycle(63, 1'b0);

    repeat (8) idle();
    cmp("drain0", exp_data[0].size(), 0);
    cmp("drain1", exp_data[1].size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
